// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage with a single-outstanding data-memory port.
//
// Non-memory ops pass straight through to the MEM/WB latch in one edge.
// Word-aligned loads/stores are captured and held on the dmem port (state
// ACCESS) until dmem_ack or a bounded wait expires. Misaligned accesses are
// never issued. Both faults set sticky error flags.
//
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   agex_*                     upstream AGEX latch (valid, pc, op class, rd,
//                              ALU result / store data, effective address)
//   mem_stall                  upstream holds its latch while high
//   dmem_req/we/addr/wdata     memory request, stable through ACCESS
//   dmem_ack, dmem_rdata       completion strobe; load data valid with ack
//   wb_*                       registered MEM/WB latch
//   pend_valid, pend_rd        in-flight load destination for interlock
//   misalign_err, timeout_err  sticky error flags, cleared only by reset
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int DBITS       = 32,
    parameter int REGNOBITS   = 5,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 agex_valid,
    input  logic [DBITS-1:0]     agex_pc,
    input  logic                 agex_is_load,
    input  logic                 agex_is_store,
    input  logic                 agex_wr_reg,
    input  logic [REGNOBITS-1:0] agex_rd,
    input  logic [DBITS-1:0]     agex_arith,
    input  logic [DBITS-1:0]     agex_memaddr,
    output logic                 mem_stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DBITS-1:0]     dmem_addr,
    output logic [DBITS-1:0]     dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DBITS-1:0]     dmem_rdata,
    output logic                 wb_valid,
    output logic                 wb_wr_reg,
    output logic [DBITS-1:0]     wb_pc,
    output logic [DBITS-1:0]     wb_value,
    output logic [REGNOBITS-1:0] wb_rd,
    output logic                 pend_valid,
    output logic [REGNOBITS-1:0] pend_rd,
    output logic                 misalign_err,
    output logic                 timeout_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int                CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Captured memory op, held on the dmem port for the whole ACCESS phase.
    logic [DBITS-1:0]       cap_pc_q, cap_pc_d;
    logic [DBITS-1:0]       cap_addr_q, cap_addr_d;
    logic [DBITS-1:0]       cap_data_q, cap_data_d;
    logic [REGNOBITS-1:0]   cap_rd_q, cap_rd_d;
    logic                   cap_wr_reg_q, cap_wr_reg_d;
    logic                   cap_store_q, cap_store_d;

    logic                   wb_valid_q, wb_valid_d;
    logic                   wb_wr_reg_q, wb_wr_reg_d;
    logic [DBITS-1:0]       wb_pc_q, wb_pc_d;
    logic [DBITS-1:0]       wb_value_q, wb_value_d;
    logic [REGNOBITS-1:0]   wb_rd_q, wb_rd_d;
    logic                   misalign_q, misalign_d;
    logic                   timeout_q, timeout_d;

    logic                   is_mem_op;
    logic                   aligned;

    assign is_mem_op = agex_is_load | agex_is_store;
    assign aligned   = (agex_memaddr[1:0] == 2'b00);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the
        // case below leaves a signal unassigned (which would infer a latch).
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_pc_d     = cap_pc_q;
        cap_addr_d   = cap_addr_q;
        cap_data_d   = cap_data_q;
        cap_rd_d     = cap_rd_q;
        cap_wr_reg_d = cap_wr_reg_q;
        cap_store_d  = cap_store_q;
        wb_valid_d   = 1'b0;
        wb_wr_reg_d  = wb_wr_reg_q;
        wb_pc_d      = wb_pc_q;
        wb_value_d   = wb_value_q;
        wb_rd_d      = wb_rd_q;
        misalign_d   = misalign_q;
        timeout_d    = timeout_q;

        case (state_q)
            IDLE: begin
                // dmem_ack is deliberately not looked at here.
                if (agex_valid) begin
                    if (!is_mem_op) begin
                        wb_valid_d  = 1'b1;
                        wb_pc_d     = agex_pc;
                        wb_rd_d     = agex_rd;
                        wb_wr_reg_d = agex_wr_reg;
                        wb_value_d  = agex_arith;
                    end else if (aligned) begin
                        state_d      = ACCESS;
                        cnt_d        = '0;
                        cap_pc_d     = agex_pc;
                        cap_addr_d   = agex_memaddr;
                        cap_data_d   = agex_arith;
                        cap_rd_d     = agex_rd;
                        cap_wr_reg_d = agex_wr_reg;
                        cap_store_d  = agex_is_store;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Ack is tested first so it wins over a coincident timeout.
                if (dmem_ack) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_pc_d    = cap_pc_q;
                    wb_rd_d    = cap_rd_q;
                    if (cap_store_q) begin
                        wb_value_d  = cap_data_q;
                        wb_wr_reg_d = 1'b0;
                    end else begin
                        wb_value_d  = dmem_rdata;
                        wb_wr_reg_d = cap_wr_reg_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cap_pc_q     <= '0;
            cap_addr_q   <= '0;
            cap_data_q   <= '0;
            cap_rd_q     <= '0;
            cap_wr_reg_q <= 1'b0;
            cap_store_q  <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_wr_reg_q  <= 1'b0;
            wb_pc_q      <= '0;
            wb_value_q   <= '0;
            wb_rd_q      <= '0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_pc_q     <= cap_pc_d;
            cap_addr_q   <= cap_addr_d;
            cap_data_q   <= cap_data_d;
            cap_rd_q     <= cap_rd_d;
            cap_wr_reg_q <= cap_wr_reg_d;
            cap_store_q  <= cap_store_d;
            wb_valid_q   <= wb_valid_d;
            wb_wr_reg_q  <= wb_wr_reg_d;
            wb_pc_q      <= wb_pc_d;
            wb_value_q   <= wb_value_d;
            wb_rd_q      <= wb_rd_d;
            misalign_q   <= misalign_d;
            timeout_q    <= timeout_d;
        end
    end

    assign mem_stall    = (state_q == ACCESS);
    assign dmem_req     = mem_stall;
    assign dmem_we      = mem_stall & cap_store_q;
    assign dmem_addr    = cap_addr_q;
    assign dmem_wdata   = cap_data_q;

    assign pend_valid   = mem_stall & ~cap_store_q & cap_wr_reg_q;
    assign pend_rd      = pend_valid ? cap_rd_q : '0;

    assign wb_valid     = wb_valid_q;
    assign wb_wr_reg    = wb_wr_reg_q;
    assign wb_pc        = wb_pc_q;
    assign wb_value     = wb_value_q;
    assign wb_rd        = wb_rd_q;
    assign misalign_err = misalign_q;
    assign timeout_err  = timeout_q;

endmodule
